gpio_pwm: RTL and testbench
===========================

GPIO_PWM -- requirements
Module: gpio_pwm

Interface
REQ-001 SHALL have parameter DIV, default 4: clocks per PWM step; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port gpio_in  input  32  GPIO output register word, consumed as four 8-bit duty values; channel i = gpio_in[8i+7:8i].
REQ-005 SHALL have port pwm  output  4  registered PWM outputs, bit i = channel i.
REQ-006 SHALL have port period_start  output  1  registered one-clock pulse marking the first step of each PWM period.

Function
REQ-007 SHALL hold a prescaler pre counting 0..DIV-1, wrapping to 0; tick = (pre == DIV-1); DIV=1 gives tick every clock.
REQ-008 SHALL hold an 8-bit step counter cnt that advances only on tick: cnt 254 -> 0, otherwise cnt+1; value 255 never occurs.
REQ-009 SHALL give a PWM period of exactly 255*DIV clocks.
REQ-010 SHALL hold four 8-bit duty registers duty_q[0..3], loaded from gpio_in per the Configuration section.
REQ-011 SHALL register pwm[i] <= (cnt < duty_q[i]), unsigned, every clock; one-clock latency from cnt/duty_q to pwm.
REQ-012 SHALL yield duty 0 -> pwm[i] constantly 0; duty 255 -> constantly 1; duty d -> high for d*DIV of every 255*DIV clocks.
REQ-013 SHALL register period_start <= tick AND (cnt == 254); high exactly one clock, the clock in which cnt first reads 0.
REQ-014 SHALL treat all four channels identically and in phase; all rise at cnt = 0 when duty > 0.
REQ-015 SHALL give no bus handshake; gpio_in is sampled every clock, with no valid/ready.

Reset
REQ-016 SHALL, while resetn = 0 at a rising clk edge, set pre = 0, cnt = 0, duty_q[0..3] = 0, pwm = 4'b0000, period_start = 0.
REQ-017 SHALL let reset mid-period abandon the period; the first clock after release restarts at pre = 0, cnt = 0.
REQ-018 SHALL keep pwm = 0 for the first clock after release; it follows REQ-011 thereafter.

Configuration
REQ-019 SHALL use macro PWM_SYNC_UPDATE_EN.
REQ-020 SHALL, with PWM_SYNC_UPDATE_EN defined, load duty_q from gpio_in only on the clock where tick AND cnt == 254 (period boundary); a mid-period gpio_in change takes effect from the next period_start, glitch-free.
REQ-021 SHALL, with PWM_SYNC_UPDATE_EN undefined, load duty_q from gpio_in every clock; a change affects pwm two clocks later, mid-period.

Verification
REQ-022 SHALL cover: DIV=1, gpio_in=32'h000000FF -> pwm[0] constantly 1, pwm[3:1] constantly 0, after the first period boundary.
REQ-023 SHALL cover: DIV=1, gpio_in=32'h40C08000 -> per 255-clock period, high counts ch0=0, ch1=128, ch2=192, ch3=64.
REQ-024 SHALL cover: DIV=4 -> period_start pulses exactly every 1020 clocks; with ch0 duty 8'h10, pwm[0] high 64 clocks per period.
REQ-025 SHALL cover: PWM_SYNC_UPDATE_EN, DIV=1, ch0 duty 0x20 -> 0xF0 at cnt=10 -> current period high 32 clocks, next period high 240 clocks.
REQ-026 SHALL cover: PWM_SYNC_UPDATE_EN undefined, same stimulus -> pwm[0] re-rises two clocks after the change, within the same period.
REQ-027 SHALL cover: resetn low one clock at cnt=100 -> next clock pwm=0, period_start=0; cnt=0 and duty_q=0 after release; period_start first fires 255*DIV clocks later.

Source files
------------

// File: rtl/gpio_pwm.sv
// gpio_pwm: four-channel PWM generator driven by a 32-bit GPIO output word.
// Each byte of gpio_in is a duty value (0 = always low, 255 = always high).
// One PWM step lasts DIV clocks; one period is 255 steps (cnt 0..254).
//
// Optional feature macro: PWM_SYNC_UPDATE_EN
//   defined   : duty registers reload only at the period boundary, so a duty
//               change never produces a truncated or stretched pulse.
//   undefined : duty registers follow gpio_in every clock.
module gpio_pwm #(
   parameter int unsigned DIV = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] gpio_in,
   output logic [3:0]  pwm,
   output logic        period_start
);

   localparam int unsigned     PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [7:0]       CNT_LAST = 8'd254;

   logic [PRE_W-1:0] pre;
   logic [7:0]       cnt;
   logic [7:0]       duty_q [4];
   logic             tick;
   logic             boundary;
   logic             load_duty;

   assign tick     = (pre == PRE_LAST);
   assign boundary = tick && (cnt == CNT_LAST);

`ifdef PWM_SYNC_UPDATE_EN
   assign load_duty = boundary;
`else
   assign load_duty = 1'b1;
`endif

   // prescaler: counts 0..DIV-1, tick on the last count
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // step counter: 0..254, advances once per tick
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= 8'd0;
      end else if (tick) begin
         if (cnt == CNT_LAST) begin
            cnt <= 8'd0;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // duty registers: byte i of gpio_in feeds channel i
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 4; i++) begin
            duty_q[i] <= 8'd0;
         end
      end else if (load_duty) begin
         for (int i = 0; i < 4; i++) begin
            duty_q[i] <= gpio_in[8*i +: 8];
         end
      end
   end

   // registered compare; all channels share cnt so they rise together at cnt 0
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pwm <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            pwm[i] <= (cnt < duty_q[i]);
         end
      end
   end

   // one-clock marker aligned with the clock in which cnt reads 0
   always_ff @(posedge clk) begin
      if (!resetn) begin
         period_start <= 1'b0;
      end else begin
         period_start <= boundary;
      end
   end

endmodule

// File: tb/tb_gpio_pwm.sv
// tb_gpio_pwm: drives two gpio_pwm instances (DIV=1 and DIV=4) from a shared
// gpio_in/resetn and checks them every clock against an elapsed-clock model,
// plus per-period high counts for directed scenarios.
module tb_gpio_pwm;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] gpio_in = 32'h0;
   logic [3:0]  pwm1, pwm4;
   logic        ps1, ps4;

   int n_checks = 0;
   int n_errors = 0;

   int h1 [4];
   int h4 [4];

   always #5 clk = ~clk;

   gpio_pwm #(.DIV(1)) u_div1 (
      .clk          (clk),
      .resetn       (resetn),
      .gpio_in      (gpio_in),
      .pwm          (pwm1),
      .period_start (ps1)
   );

   gpio_pwm #(.DIV(4)) u_div4 (
      .clk          (clk),
      .resetn       (resetn),
      .gpio_in      (gpio_in),
      .pwm          (pwm4),
      .period_start (ps4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: after the e-th clock since reset, the step index is
   // floor(e/DIV) mod 255 and a period boundary occurs when e is a multiple
   // of 255*DIV. pwm shows the step/duty of the previous clock.
   int         e_clk;
   logic [7:0] m_cnt  [2];
   logic [7:0] m_duty [2][4];

   always @(posedge clk) begin : ref_model
      logic [31:0] g;
      logic        r;
      logic [3:0]  exp_pwm;
      logic        exp_ps;
      logic [3:0]  got_pwm;
      logic        got_ps;
      int          d;
      int          p;
      g = gpio_in;
      r = resetn;
      #1;
      if (!r) e_clk = 0;
      else    e_clk = e_clk + 1;
      for (int k = 0; k < 2; k++) begin
         d = (k == 0) ? 1 : 4;
         p = 255 * d;
         exp_pwm = 4'b0000;
         exp_ps  = 1'b0;
         if (r) begin
            for (int i = 0; i < 4; i++) exp_pwm[i] = (m_cnt[k] < m_duty[k][i]);
            exp_ps = ((e_clk % p) == 0);
         end
         if (k == 0) begin
            got_pwm = pwm1;
            got_ps  = ps1;
            chk("model_pwm_div1", {28'h0, got_pwm}, {28'h0, exp_pwm});
            chk("model_ps_div1", {31'h0, got_ps}, {31'h0, exp_ps});
         end else begin
            got_pwm = pwm4;
            got_ps  = ps4;
            chk("model_pwm_div4", {28'h0, got_pwm}, {28'h0, exp_pwm});
            chk("model_ps_div4", {31'h0, got_ps}, {31'h0, exp_ps});
         end
         if (!r) begin
            m_cnt[k] = 8'd0;
            for (int i = 0; i < 4; i++) m_duty[k][i] = 8'd0;
         end else begin
            m_cnt[k] = 8'((e_clk / d) % 255);
`ifdef PWM_SYNC_UPDATE_EN
            if ((e_clk % p) == 0)
               for (int i = 0; i < 4; i++) m_duty[k][i] = g[8*i +: 8];
`else
            for (int i = 0; i < 4; i++) m_duty[k][i] = g[8*i +: 8];
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic measure(input int n);
      for (int i = 0; i < 4; i++) begin
         h1[i] = 0;
         h4[i] = 0;
      end
      repeat (n) begin
         step();
         for (int i = 0; i < 4; i++) begin
            h1[i] += int'(pwm1[i]);
            h4[i] += int'(pwm4[i]);
         end
      end
   endtask

   task automatic wait_ps(input int which);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         step();
         if ((which == 0 && ps1) || (which == 1 && ps4)) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("wait_period_start_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [7:0] rand_duty();
      logic [7:0] v;
      case ($urandom_range(0, 4))
         0:       v = 8'd0;
         1:       v = 8'd255;
         2:       v = 8'd1;
         3:       v = 8'd254;
         default: v = 8'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      int         k;
      int         c_a, c_b;
      int         first1, first4;
      logic [7:0] dv [4];

      resetn  = 1'b0;
      gpio_in = 32'hFFFF_FFFF;
      repeat (3) step();
      chk("reset_pwm_div1", {28'h0, pwm1}, 32'd0);
      chk("reset_ps_div1", {31'h0, ps1}, 32'd0);
      chk("reset_pwm_div4", {28'h0, pwm4}, 32'd0);
      chk("reset_ps_div4", {31'h0, ps4}, 32'd0);
      resetn = 1'b1;
      step();
      chk("first_clk_pwm_div1", {28'h0, pwm1}, 32'd0);

      // channel 0 full on, others off
      gpio_in = 32'h0000_00FF;
      repeat (2100) step();
      measure(255);
      chk("full_on_ch0", h1[0], 255);
      chk("full_on_ch1", h1[1], 0);
      chk("full_on_ch2", h1[2], 0);
      chk("full_on_ch3", h1[3], 0);

      // mixed duties; 1020 clocks = 4 periods at DIV=1, 1 period at DIV=4
      gpio_in = 32'h40C0_8000;
      repeat (2100) step();
      measure(1020);
      chk("mix_div1_ch0", h1[0], 4 * 0);
      chk("mix_div1_ch1", h1[1], 4 * 128);
      chk("mix_div1_ch2", h1[2], 4 * 192);
      chk("mix_div1_ch3", h1[3], 4 * 64);
      chk("mix_div4_ch1", h4[1], 4 * 128);
      chk("mix_div4_ch2", h4[2], 4 * 192);
      chk("mix_div4_ch3", h4[3], 4 * 64);

      // DIV=4 period length and duty 0x10
      gpio_in = 32'h0000_0010;
      repeat (2100) step();
      wait_ps(1);
      k = 0;
      for (int n = 0; n < 2000; n++) begin
         step();
         k++;
         if (ps4) break;
      end
      chk("ps_interval_div4", k, 1020);
      measure(1020);
      chk("div4_duty10_high", h4[0], 64);

      // duty 0x20 -> 0xF0 at cnt 10
      gpio_in = 32'h0000_0020;
      wait_ps(0);
      wait_ps(0);
      c_a = 0;
      c_b = 0;
      for (int n = 1; n <= 510; n++) begin
         step();
         if (n <= 255) c_a += int'(pwm1[0]);
         else          c_b += int'(pwm1[0]);
         if (n == 10) gpio_in = 32'h0000_00F0;
      end
`ifdef PWM_SYNC_UPDATE_EN
      chk("update_cur_period", c_a, 32);
`else
      chk("update_cur_period", c_a, 240);
`endif
      chk("update_next_period", c_b, 240);

      // duty 0x05 -> 0x80 at cnt 10: re-rise timing
      gpio_in = 32'h0000_0005;
      wait_ps(0);
      wait_ps(0);
      repeat (10) step();
      chk("rerise_before", {31'h0, pwm1[0]}, 32'd0);
      gpio_in = 32'h0000_0080;
      step();
      chk("rerise_plus1", {31'h0, pwm1[0]}, 32'd0);
      step();
`ifdef PWM_SYNC_UPDATE_EN
      chk("rerise_plus2", {31'h0, pwm1[0]}, 32'd0);
`else
      chk("rerise_plus2", {31'h0, pwm1[0]}, 32'd1);
`endif

      // reset pulse at cnt 100
      gpio_in = 32'hFFFF_FFFF;
      wait_ps(0);
      repeat (100) step();
      resetn = 1'b0;
      step();
      chk("midreset_pwm_div1", {28'h0, pwm1}, 32'd0);
      chk("midreset_ps_div1", {31'h0, ps1}, 32'd0);
      chk("midreset_pwm_div4", {28'h0, pwm4}, 32'd0);
      resetn = 1'b1;
      first1 = 0;
      first4 = 0;
      for (int n = 1; n <= 1100; n++) begin
         step();
         if (n == 1) begin
            chk("release_pwm_div1", {28'h0, pwm1}, 32'd0);
            chk("release_pwm_div4", {28'h0, pwm4}, 32'd0);
         end
         if (ps1 && first1 == 0) first1 = n;
         if (ps4 && first4 == 0) first4 = n;
      end
      chk("release_first_ps_div1", first1, 255);
      chk("release_first_ps_div4", first4, 1020);

      // random held duties, whole-period high counts
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < 4; i++) dv[i] = rand_duty();
         gpio_in = {dv[3], dv[2], dv[1], dv[0]};
         repeat (2100) step();
         measure(1020);
         for (int i = 0; i < 4; i++) begin
            chk("rand_hold_div1", h1[i], 4 * int'(dv[i]));
            chk("rand_hold_div4", h4[i], 4 * int'(dv[i]));
         end
      end

      // random churn with occasional resets; per-clock model does the checking
      for (int n = 0; n < 6000; n++) begin
         if ($urandom_range(0, 39) == 0)
            gpio_in = {rand_duty(), rand_duty(), rand_duty(), rand_duty()};
         resetn = ($urandom_range(0, 1999) != 0);
         step();
      end
      resetn = 1'b1;
      repeat (5) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
